instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  LEGv8 fetch stage: owns the PC and issues word fetches to instruction memory over a valid/ready
//  request channel with in-order responses. Buffers fetched words in a small FIFO and presents
//  {inst, inst_pc} to the decode/control stage with a valid/ready handshake.
//  Accepts resolved branch redirects (CBZ / B) from downstream, flushing buffered and in-flight fetches.
// PARAMETERS
//  ADDR_W    64  PC / memory address width
//  RESET_PC  0   PC value loaded on reset
//  DEPTH     4   FIFO entries = max outstanding + buffered words; power of two, >=2
// PORTS
//  clk             in   1       clock, all state updates on rising edge
//  rst_n           in   1       asynchronous active-low reset
//  imem_req_valid  out  1       fetch request valid
//  imem_req_ready  in   1       memory accepts request
//  imem_req_addr   out  ADDR_W  byte address of requested word (always 4-aligned)
//  imem_rsp_valid  in   1       response word valid (one per accepted request, in order, latency>=1)
//  imem_rsp_data   in   32      fetched instruction word
//  inst_valid      out  1       decode-side word valid
//  inst_ready      in   1       decode stage consumes word
//  inst            out  32      instruction to control unit / decode
//  inst_pc         out  ADDR_W  address of inst
//  br_valid        in   1       branch resolved this cycle
//  br_taken        in   1       branch taken (UNCOND_BRANCH, or BRANCH with zero flag)
//  br_pc           in   ADDR_W  address of the branch instruction
//  br_offset       in   ADDR_W  sign-extended word offset (imm26 for B, imm19 for CBZ)
//  halted          out  1       halt instruction reached (0 when IFU_HALT_DETECT_EN undefined)
// BEHAVIOUR
//  Reset: all outputs 0; pc<=RESET_PC, rsp_pc<=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
//  Credit: issue allowed when fifo_count + outstanding < DEPTH, no redirect this cycle, not halted.
//  imem_req_valid = credit; imem_req_addr = pc. Handshake (valid&ready): pc<=pc+4, outstanding++.
//  Held request not yet accepted may be withdrawn only by redirect; reissued next cycle at new pc.
//  Response: outstanding--. If drop_cnt>0: discard word, drop_cnt--. Else push {data, rsp_pc}, rsp_pc+=4.
//  Output: inst_valid = FIFO non-empty; inst/inst_pc = head (registered); pop on inst_valid&inst_ready.
//  Latency: request accepted cycle N, response N+k -> inst_valid at N+k+1 (no bypass).
//  Redirect = br_valid & br_taken. target = br_pc + (br_offset << 2), mod 2^ADDR_W (wraps silently).
//   Same edge: pc<=target, rsp_pc<=target, FIFO flushed, inst_valid 0 next cycle, no request issued.
//   drop_cnt <= outstanding_next (includes request accepted and excludes response arriving that cycle).
//   Response arriving in redirect cycle is discarded. Pop in redirect cycle is ignored (flush wins).
//  br_valid & !br_taken: no effect. Redirect while drop_cnt>0: drop_cnt recomputed as above.
//  Simultaneous push and pop on full FIFO legal; credit rule prevents overflow; rsp on full FIFO impossible.
//  Counters outstanding, drop_cnt, fifo_count: width $clog2(DEPTH+1); never wrap.
//  FSM (2-bit): RUN (issue per credit) -> DRAIN when drop_cnt>0 after redirect (issue allowed,
//   stale responses discarded) -> RUN when drop_cnt==0; any -> HALT (macro only); reset -> RUN.
//  Reset mid-operation: all state cleared asynchronously; responses to pre-reset requests are the
//  memory's responsibility to suppress (memory shares rst_n).
// CONFIGURATION
//  IFU_HALT_DETECT_EN defined: word 32'hD4400000 (HLT) pushed into FIFO -> FSM HALT; no further
//   requests; halted=1 after that word is popped; in-flight responses drained and discarded;
//   taken redirect in HALT (before HLT popped) returns to RUN/DRAIN and clears halted.
//  Undefined: HLT treated as ordinary word; halted tied 0; HALT state absent.
// TESTING
//  Reset: rst_n low mid-fetch -> all outputs 0 immediately; after release first imem_req_addr=RESET_PC.
//  Straight-line, 1-cycle memory, inst_ready=1 -> addrs 0,4,8,12...; inst_pc matches; 1 word/cycle steady.
//  inst_ready=0, DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0 until a pop.
//  3-cycle memory, 2 outstanding, redirect br_pc=0x10 off=-2 -> next addr 0x08; 2 stale rsps dropped.
//  Redirect same cycle as rsp and pop -> FIFO empty next cycle, rsp dropped, first inst_pc=target.
//  Macro on: HLT at 0x0C -> words 0x0..0x0C delivered, no request past 0x10, halted=1 after HLT pop.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch-stage bundle: imem request/response, decode handshake, branch redirect
// master = the fetch unit, slave = the memory / decode / branch-resolution side.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 64
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              br_valid;
  logic              br_taken;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] br_offset;
  logic              halted;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, halted,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           br_valid, br_taken, br_pc, br_offset
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, halted,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           br_valid, br_taken, br_pc, br_offset
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - LEGv8 fetch stage: PC, credit-limited imem requests, word FIFO, branch redirect
// Optional halt detection (HLT word stops fetching) is enabled by defining IFU_HALT_DETECT_EN.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  instruction_fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] LP_DEPTH = (CW + 1)'(DEPTH);

`ifdef IFU_HALT_DETECT_EN
  localparam logic [31:0] HLT_WORD = 32'hD440_0000;
  typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1, S_HALT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1} state_t;
`endif

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_rsp_pc;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_drop_cnt;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [31:0]       r_mem_data [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
  logic              r_started;
  logic              r_halted;

  logic              w_redirect;
  logic [ADDR_W-1:0] w_target;
  logic              w_in_halt;
  logic [CW:0]       w_occupancy;
  logic              w_credit;
  logic              w_req_fire;
  logic              w_discard;
  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_out_next;
  logic [CW-1:0]     w_drop_next;

  assign w_redirect  = bus.br_valid & bus.br_taken;
  assign w_target    = bus.br_pc + (bus.br_offset << 2);
  assign w_occupancy = {1'b0, r_count} + {1'b0, r_outstanding};

  // r_started keeps imem_req_valid low while rst_n is asserted, even though the counters read as empty.
  assign w_credit   = r_started & ~w_redirect & ~w_in_halt & (w_occupancy < LP_DEPTH);
  assign w_req_fire = w_credit & bus.imem_req_ready;

  assign w_discard  = w_redirect | w_in_halt | (r_drop_cnt != '0);
  assign w_push     = bus.imem_rsp_valid & ~w_discard;
  assign w_pop      = bus.inst_valid & bus.inst_ready & ~w_redirect;
  assign w_out_next = r_outstanding + CW'(w_req_fire) - CW'(bus.imem_rsp_valid);

  always_comb begin
    w_drop_next = r_drop_cnt;
    if (w_redirect) begin
      w_drop_next = w_out_next;
    end else if (bus.imem_rsp_valid && r_drop_cnt != '0) begin
      w_drop_next = r_drop_cnt - CW'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_halt    = 1'b0;
`ifdef IFU_HALT_DETECT_EN
    w_in_halt    = (r_state == S_HALT);
`endif
    if (w_redirect) begin
      w_state_next = (w_out_next != '0) ? S_DRAIN : S_RUN;
    end else begin
      case (r_state)
        S_DRAIN: if (w_drop_next == '0) w_state_next = S_RUN;
        default: w_state_next = r_state;
      endcase
`ifdef IFU_HALT_DETECT_EN
      if (w_push && bus.imem_rsp_data == HLT_WORD) w_state_next = S_HALT;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started     <= 1'b0;
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_started     <= 1'b1;
      r_outstanding <= w_out_next;
      r_drop_cnt    <= w_drop_next;
      if (w_redirect) begin
        r_pc     <= w_target;
        r_rsp_pc <= w_target;
      end else begin
        if (w_req_fire) r_pc <= r_pc + ADDR_W'(4);
        if (w_push) r_rsp_pc <= r_rsp_pc + ADDR_W'(4);
      end
    end
  end

  // Word FIFO; a redirect flushes it in the same edge and overrides any pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_pc[i]   <= '0;
      end
    end else if (w_redirect) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wptr] <= bus.imem_rsp_data;
        r_mem_pc[r_wptr]   <= r_rsp_pc;
        r_wptr             <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

`ifdef IFU_HALT_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
    end else if (w_redirect) begin
      r_halted <= 1'b0;
    end else if (w_pop && w_in_halt && bus.inst == HLT_WORD) begin
      r_halted <= 1'b1;
    end
  end
`else
  assign r_halted = 1'b0;
`endif

  assign bus.imem_req_valid = w_credit;
  assign bus.imem_req_addr  = r_pc;
  assign bus.inst_valid     = (r_count != '0);
  assign bus.inst           = r_mem_data[r_rptr];
  assign bus.inst_pc        = r_mem_pc[r_rptr];
  assign bus.halted         = r_halted;

endmodule
